pixel_write_scheduler: RTL and testbench
========================================

// Module: pixel_write_scheduler
// PURPOSE
//  Shares the single VGA adapter write port between the drawing requesters: cursor animation
//  (move/clean), brush (draw/erase) and screen clear. Each requester posts a filled-rectangle job.
//  The block arbitrates round-robin, then sweeps the granted rectangle one pixel per clock.
//  It drives x/y/colour/plot to the adapter and returns a one-cycle done pulse to the winner.
// PARAMETERS
//  NREQ      3    number of requesters (0=cursor, 1=brush, 2=clear)
//  X_W       8    x coordinate / width bits
//  Y_W       7    y coordinate / height bits
//  COLOUR_W  3    colour bits
//  SCREEN_W  160  visible columns; x >= SCREEN_W is clipped
//  SCREEN_H  120  visible rows; y >= SCREEN_H is clipped
// PORTS
//  iClk     in   1               clock
//  iResetn  in   1               reset, asynchronous, active-low
//  iReq     in   NREQ            per-requester job request, level, held until its oDone
//  iX0      in   NREQ*X_W        packed top-left x per requester (slice i = [i*X_W +: X_W])
//  iY0      in   NREQ*Y_W        packed top-left y
//  iW       in   NREQ*X_W        packed rectangle width in pixels (0 = empty job)
//  iH       in   NREQ*Y_W        packed rectangle height in pixels (0 = empty job)
//  iColour  in   NREQ*COLOUR_W   packed fill colour
//  oGrant   out  NREQ            one-hot, high while the job owns the port
//  oDone    out  NREQ            one-hot, one-cycle pulse at job end
//  oX       out  X_W             adapter x
//  oY       out  Y_W             adapter y
//  oColour  out  COLOUR_W        adapter colour
//  oPlot    out  1               adapter write strobe
//  oBusy    out  1               high in any state other than IDLE
// BEHAVIOUR
//  Reset: state IDLE. oGrant, oDone, oPlot, oBusy, oX, oY and oColour are all 0. RR pointer = 0.
//  All outputs are registered.
//  FSM: IDLE -> SWEEP -> DONE -> IDLE.
//   IDLE: if any iReq bit is set, pick the first set bit searching from ptr upward (wrapping).
//    Latch that requester's x0/y0/w/h/colour, set oGrant[i], and clear cx/cy to 0.
//    If w==0 or h==0, go to DONE; otherwise go to SWEEP.
//   SWEEP: each cycle present oX=x0+cx, oY=y0+cy, oColour=latched colour.
//    oPlot=1 only if x0+cx < SCREEN_W and y0+cy < SCREEN_H. Compare with X_W+1 / Y_W+1 bit sums;
//    no wrap-around onto the screen. Clipped pixels still take their cycle.
//    Order is row-major: cx++ until w-1, then cx=0 and cy++. After pixel (w-1,h-1), go to DONE.
//   DONE: oPlot=0, oDone[i]=1 for one cycle, oGrant cleared. ptr <= (i+1) mod NREQ. Go to IDLE.
//  Latency: a request seen in IDLE at edge k gives grant at k+1 and the first plot in cycle k+1.
//   oDone appears at k+1+w*h. The block returns to IDLE at k+2+w*h.
//   An empty job pulses oDone at k+2.
//  iReq still high in IDLE after oDone counts as a new job. Round-robin guarantees the other
//   requesters are served first.
//  iReq dropped mid-job is ignored: the job is not aborted. Operand changes mid-job are ignored.
//  Simultaneous requests: only the pointer order matters. No requester is starved for more than
//   NREQ-1 jobs.
//  Reset mid-sweep: outputs go to 0 immediately (async). No oDone is issued for the aborted job.
// STRUCTURE
//  drawing_pkg: FSM state encodings, SCREEN_W/SCREEN_H, requester indices REQ_CURSOR=0,
//   REQ_BRUSH=1, REQ_CLEAR=2.
//  Sub-module rr_arbiter (NREQ): iReq, iPtr -> one-hot oSel plus oAny. Purely combinational.
//  The scheduler owns ptr, the operand latch, the cx/cy counters and the output registers.
// TESTING
//  1. Brush req only, (10,20) 3x3, colour 5 -> 9 plots at (10..12,20..22) row-major, colour 5.
//     oDone[1] in cycle 10 after grant start.
//  2. All three req the same cycle after reset, each 1x1 -> grants in order 0,1,2.
//     Then a held iReq[0] is served again after 2 completes.
//  3. Job (158,118) 4x4 -> 16 sweep cycles. oPlot only at (158..159,118..119) = 4 plots.
//     oDone after 16 cycles.
//  4. w=0, h=5 -> no oPlot, oDone pulse 2 cycles after request, back to IDLE.
//  5. Clear 160x120 at (0,0) -> 19200 plots, last at (159,119), a single oDone[2] pulse.
//  6. Pull iResetn low during a sweep at pixel 4 -> all outputs 0 that cycle, no oDone.
//     After release, IDLE with ptr=0.

Source files
------------

// File: rtl/drawing_pkg.sv
// Shared definitions for the drawing datapath: scheduler FSM encodings,
// visible screen size, requester slot indices and a pointer-width helper.
package drawing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;

  localparam int REQ_CURSOR = 0;
  localparam int REQ_BRUSH  = 1;
  localparam int REQ_CLEAR  = 2;

  // Bits needed to hold a requester index (at least one).
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// Ports:
//   iReq  in  NREQ  request vector
//   iPtr  in  PW    highest-priority index for this pick
//   oSel  out NREQ  one-hot winner (first set bit from iPtr upward, wrapping)
//   oAny  out 1     any request present
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = drawing_pkg::ptr_w(NREQ)
) (
  input  logic [NREQ-1:0] iReq,
  input  logic [PW-1:0]   iPtr,
  output logic [NREQ-1:0] oSel,
  output logic            oAny
);

  logic found;
  int   idx;

  always_comb begin
    oSel  = '0;
    found = 1'b0;
    idx   = 0;
    for (int o = 0; o < NREQ; o++) begin
      // iPtr < 2^PW < 2*NREQ, so a single subtraction wraps the index
      idx = int'(iPtr) + o;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && iReq[idx]) begin
        oSel[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign oAny = |iReq;

endmodule

// File: rtl/pixel_write_scheduler.sv
// Shares the single VGA adapter write port between drawing requesters.
// Each requester posts a filled rectangle; the winner of a round-robin pick
// has its rectangle swept row-major, one pixel per clock, and gets a
// one-cycle done pulse at the end.
// Ports:
//   iClk, iResetn               clock, async active-low reset
//   iReq     in  NREQ           level request, held until oDone
//   iX0/iY0  in  packed         top-left corner per requester
//   iW/iH    in  packed         rectangle size (0 = empty job)
//   iColour  in  packed         fill colour
//   oGrant   out NREQ           one-hot owner of the port
//   oDone    out NREQ           one-cycle completion pulse
//   oX/oY/oColour/oPlot         adapter write interface
//   oBusy    out 1              FSM not idle
module pixel_write_scheduler #(
  parameter int NREQ     = 3,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = drawing_pkg::SCREEN_W,
  parameter int SCREEN_H = drawing_pkg::SCREEN_H
) (
  input  logic                     iClk,
  input  logic                     iResetn,
  input  logic [NREQ-1:0]          iReq,
  input  logic [NREQ*X_W-1:0]      iX0,
  input  logic [NREQ*Y_W-1:0]      iY0,
  input  logic [NREQ*X_W-1:0]      iW,
  input  logic [NREQ*Y_W-1:0]      iH,
  input  logic [NREQ*COLOUR_W-1:0] iColour,
  output logic [NREQ-1:0]          oGrant,
  output logic [NREQ-1:0]          oDone,
  output logic [X_W-1:0]           oX,
  output logic [Y_W-1:0]           oY,
  output logic [COLOUR_W-1:0]      oColour,
  output logic                     oPlot,
  output logic                     oBusy
);
  import drawing_pkg::*;

  localparam int             PW       = ptr_w(NREQ);
  localparam logic [PW-1:0]  LAST_IDX = PW'(NREQ-1);
  // Clip limits one bit wider than the coordinates so x0+cx never wraps
  localparam logic [X_W:0]   XLIM     = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]   YLIM     = (Y_W+1)'(SCREEN_H);

  state_t                state;
  logic [PW-1:0]         ptr, own;
  logic [X_W-1:0]        x0_q, w_q, cx;
  logic [Y_W-1:0]        y0_q, h_q, cy;
  logic [COLOUR_W-1:0]   col_q;

  // ---------------- arbitration ----------------
  logic [NREQ-1:0] sel;
  logic            any;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .iReq (iReq),
    .iPtr (ptr),
    .oSel (sel),
    .oAny (any)
  );

  // Operands of the selected requester
  logic [PW-1:0]       s_idx;
  logic [X_W-1:0]      s_x0, s_w;
  logic [Y_W-1:0]      s_y0, s_h;
  logic [COLOUR_W-1:0] s_col;
  logic                s_empty, s_on;

  always_comb begin
    s_idx = '0;
    s_x0  = '0;
    s_y0  = '0;
    s_w   = '0;
    s_h   = '0;
    s_col = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel[i]) begin
        s_idx = PW'(i);
        s_x0  = iX0[i*X_W +: X_W];
        s_y0  = iY0[i*Y_W +: Y_W];
        s_w   = iW[i*X_W +: X_W];
        s_h   = iH[i*Y_W +: Y_W];
        s_col = iColour[i*COLOUR_W +: COLOUR_W];
      end
    end
    s_empty = (s_w == '0) || (s_h == '0);
    s_on    = ({1'b0, s_x0} < XLIM) && ({1'b0, s_y0} < YLIM);
  end

  // ---------------- sweep stepping ----------------
  // cx/cy index the pixel currently on the outputs; the next pixel is
  // computed here so the output registers always hold a whole pixel.
  logic           last_x, last_y;
  logic [X_W-1:0] nxt_cx;
  logic [Y_W-1:0] nxt_cy;
  logic [X_W:0]   sum_x;
  logic [Y_W:0]   sum_y;
  logic           n_on;
  logic [PW-1:0]  nxt_ptr;

  always_comb begin
    last_x  = (cx == w_q - 1'b1);
    last_y  = (cy == h_q - 1'b1);
    nxt_cx  = last_x ? '0 : cx + 1'b1;
    nxt_cy  = last_x ? cy + 1'b1 : cy;
    sum_x   = {1'b0, x0_q} + {1'b0, nxt_cx};
    sum_y   = {1'b0, y0_q} + {1'b0, nxt_cy};
    n_on    = (sum_x < XLIM) && (sum_y < YLIM);
    nxt_ptr = (own == LAST_IDX) ? '0 : own + 1'b1;
  end

  // ---------------- FSM and output registers ----------------
  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      own     <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      cx      <= '0;
      cy      <= '0;
      oGrant  <= '0;
      oDone   <= '0;
      oX      <= '0;
      oY      <= '0;
      oColour <= '0;
      oPlot   <= 1'b0;
      oBusy   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          oPlot <= 1'b0;
          if (any) begin
            own     <= s_idx;
            x0_q    <= s_x0;
            y0_q    <= s_y0;
            w_q     <= s_w;
            h_q     <= s_h;
            col_q   <= s_col;
            cx      <= '0;
            cy      <= '0;
            oGrant  <= sel;
            oBusy   <= 1'b1;
            // First pixel goes out on the same edge as the grant
            oX      <= s_x0;
            oY      <= s_y0;
            oColour <= s_col;
            if (s_empty) begin
              state <= ST_DONE;
            end else begin
              state <= ST_SWEEP;
              oPlot <= s_on;
            end
          end
        end

        ST_SWEEP: begin
          if (last_x && last_y) begin
            oPlot  <= 1'b0;
            oDone  <= oGrant;
            oGrant <= '0;
            ptr    <= nxt_ptr;
            state  <= ST_DONE;
          end else begin
            cx    <= nxt_cx;
            cy    <= nxt_cy;
            oX    <= sum_x[X_W-1:0];
            oY    <= sum_y[Y_W-1:0];
            oPlot <= n_on;
          end
        end

        ST_DONE: begin
          oPlot <= 1'b0;
          // An empty job arrives here with the grant still up: spend one
          // cycle issuing the pulse, then leave on the following edge.
          if (oDone != '0) begin
            oDone <= '0;
            oBusy <= 1'b0;
            state <= ST_IDLE;
          end else begin
            oDone  <= oGrant;
            oGrant <= '0;
            ptr    <= nxt_ptr;
          end
        end

        default: begin
          state  <= ST_IDLE;
          oGrant <= '0;
          oDone  <= '0;
          oPlot  <= 1'b0;
          oBusy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_write_scheduler.sv
module tb_pixel_write_scheduler;
  localparam int NREQ = 3;
  localparam int X_W  = 8;
  localparam int Y_W  = 7;
  localparam int C_W  = 3;

  logic                  iClk = 1'b0;
  logic                  iResetn;
  logic [NREQ-1:0]       iReq;
  logic [NREQ*X_W-1:0]   iX0, iW;
  logic [NREQ*Y_W-1:0]   iY0, iH;
  logic [NREQ*C_W-1:0]   iColour;
  logic [NREQ-1:0]       oGrant, oDone;
  logic [X_W-1:0]        oX;
  logic [Y_W-1:0]        oY;
  logic [C_W-1:0]        oColour;
  logic                  oPlot, oBusy;

  pixel_write_scheduler #(
    .NREQ(NREQ), .X_W(X_W), .Y_W(Y_W), .COLOUR_W(C_W),
    .SCREEN_W(160), .SCREEN_H(120)
  ) dut (
    .iClk(iClk), .iResetn(iResetn), .iReq(iReq),
    .iX0(iX0), .iY0(iY0), .iW(iW), .iH(iH), .iColour(iColour),
    .oGrant(oGrant), .oDone(oDone), .oX(oX), .oY(oY),
    .oColour(oColour), .oPlot(oPlot), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Post one job on slot r and follow it to its done pulse. Counts cycles
  // from the first cycle after the request edge (grant cycle = 1).
  task automatic run_job(input int r, input int x0, input int y0, input int w,
                         input int h, input int col,
                         output int plots, output int lx, output int ly,
                         output int dcyc, output int perr, output int tail_ok);
    int n, cyc, p, ex, ey;
    logic [NREQ-1:0] oh;
    logic exp_plot;
    n = w * h; cyc = 0;
    oh = '0; oh[r] = 1'b1;
    plots = 0; lx = -1; ly = -1; dcyc = -1; perr = 0;
    @(negedge iClk);
    iX0[r*X_W +: X_W]     = X_W'(x0);
    iY0[r*Y_W +: Y_W]     = Y_W'(y0);
    iW[r*X_W +: X_W]      = X_W'(w);
    iH[r*Y_W +: Y_W]      = Y_W'(h);
    iColour[r*C_W +: C_W] = C_W'(col);
    iReq[r] = 1'b1;
    while (dcyc < 0 && cyc < n + 10) begin
      @(negedge iClk);
      cyc++;
      if (oPlot) begin plots++; lx = int'(oX); ly = int'(oY); end
      if (cyc <= n) begin
        p = cyc - 1;
        ex = x0 + p % w;
        ey = y0 + p / w;
        exp_plot = (ex < 160) && (ey < 120);
        if (oX != X_W'(ex) || oY != Y_W'(ey) || oColour != C_W'(col) ||
            oPlot != exp_plot || oGrant != oh || !oBusy) perr++;
      end else if (oPlot) perr++;
      if (oDone != '0) begin
        dcyc = cyc;
        if (oDone != oh || oGrant != '0) perr++;
      end
    end
    iReq[r] = 1'b0;
    @(negedge iClk);
    tail_ok = (oDone == '0 && !oBusy && !oPlot) ? 1 : 0;
  endtask

  typedef struct {
    int r, x0, y0, w, h, col;
    int plots, lx, ly, done_cyc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int plots, lx, ly, dcyc, perr, tail_ok, c;
    int ord[$];
    int exp_ord[4];
    int act;
    bit first0, found, seen_done;

    //            r  x0   y0   w    h    col  plots  lx   ly   done
    vecs[0] = '{1, 10,  20,  3,   3,   5,   9,     12,  22,  10};
    vecs[1] = '{0, 158, 118, 4,   4,   3,   4,     159, 119, 17};
    vecs[2] = '{0, 30,  40,  0,   5,   1,   0,     -1,  -1,  2};
    vecs[3] = '{2, 0,   0,   160, 120, 0,   19200, 159, 119, 19201};
    vecs[4] = '{1, 250, 5,   10,  1,   4,   0,     -1,  -1,  11};
    vecs[5] = '{2, 5,   6,   1,   1,   7,   1,     5,   6,   2};
    vecs[6] = '{1, 100, 119, 2,   3,   2,   2,     101, 119, 7};
    exp_ord = '{0, 1, 2, 0};

    iResetn = 1'b0; iReq = '0;
    iX0 = '0; iY0 = '0; iW = '0; iH = '0; iColour = '0;
    repeat (3) @(negedge iClk);
    chk("rst_grant",  int'(oGrant),  0);
    chk("rst_done",   int'(oDone),   0);
    chk("rst_plot",   int'(oPlot),   0);
    chk("rst_busy",   int'(oBusy),   0);
    chk("rst_x",      int'(oX),      0);
    chk("rst_y",      int'(oY),      0);
    chk("rst_colour", int'(oColour), 0);
    iResetn = 1'b1;
    @(negedge iClk);

    // Simultaneous 1x1 requests; slot 0 stays held after its first job
    for (int i = 0; i < NREQ; i++) begin
      iX0[i*X_W +: X_W] = X_W'(i); iY0[i*Y_W +: Y_W] = Y_W'(i);
      iW[i*X_W +: X_W] = 8'd1;     iH[i*Y_W +: Y_W] = 7'd1;
      iColour[i*C_W +: C_W] = C_W'(i);
    end
    iReq = 3'b111;
    first0 = 1'b1;
    @(negedge iClk);
    chk("rr_first_grant", int'(oGrant), 1);
    c = 0;
    while (c < 40 && ord.size() < 4) begin
      if (oDone != '0) begin
        for (int i = 0; i < NREQ; i++) begin
          if (oDone[i]) begin
            ord.push_back(i);
            if (i == 0 && first0) first0 = 1'b0;
            else iReq[i] = 1'b0;
          end
        end
      end
      @(negedge iClk);
      c++;
    end
    iReq = '0;
    chk("rr_jobs", ord.size(), 4);
    for (int k = 0; k < 4; k++) begin
      act = (k < ord.size()) ? ord[k] : -1;
      chk($sformatf("rr_order%0d", k), act, exp_ord[k]);
    end
    repeat (3) @(negedge iClk);

    // Table of single-requester jobs
    for (int i = 0; i < 7; i++) begin
      run_job(vecs[i].r, vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h,
              vecs[i].col, plots, lx, ly, dcyc, perr, tail_ok);
      chk($sformatf("v%0d_done_cycle", i), dcyc, vecs[i].done_cyc);
      chk($sformatf("v%0d_plots", i), plots, vecs[i].plots);
      chk($sformatf("v%0d_last_x", i), lx, vecs[i].lx);
      chk($sformatf("v%0d_last_y", i), ly, vecs[i].ly);
      chk($sformatf("v%0d_pixel_errs", i), perr, 0);
      chk($sformatf("v%0d_idle_after", i), tail_ok, 1);
    end

    // Reset in the middle of a sweep, at pixel 4
    @(negedge iClk);
    iX0[1*X_W +: X_W] = 8'd0; iY0[1*Y_W +: Y_W] = 7'd0;
    iW[1*X_W +: X_W] = 8'd10; iH[1*Y_W +: Y_W] = 7'd1;
    iColour[1*C_W +: C_W] = 3'd6;
    iReq[1] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge iClk);
      if (oBusy && oX == 8'd4) found = 1'b1;
    end
    chk("mid_reached_px4", int'(found), 1);
    iResetn = 1'b0;
    #1;
    chk("mid_rst_outputs",
        int'({oGrant, oDone, oPlot, oBusy, oX, oY, oColour}), 0);
    iReq = '0;
    repeat (2) @(negedge iClk);
    iResetn = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge iClk);
      if (oDone != '0 || oBusy) seen_done = 1'b1;
    end
    chk("mid_no_done_idle", int'(seen_done), 0);

    // Pointer restarted at 0: slots 1 and 2 together must pick 1
    iW[2*X_W +: X_W] = 8'd1; iH[2*Y_W +: Y_W] = 7'd1;
    iW[1*X_W +: X_W] = 8'd1; iH[1*Y_W +: Y_W] = 7'd1;
    iReq = 3'b110;
    @(negedge iClk);
    chk("mid_ptr_reset_grant", int'(oGrant), 2);
    iReq = '0;
    repeat (4) @(negedge iClk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
